// File: rtl/instmem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : instmem_loader_if
//  Description : Host byte stream, instruction memory write port and status
//                signals of the instruction memory loader. The master modport
//                is the loader side; the slave modport is the host/memory side.
//  Revision    : 1.0  initial release
// ============================================================================
interface instmem_loader_if #(
    parameter int LENGTH = 10
);
    localparam int AW = $clog2(LENGTH);

    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          done;
    logic          error;
    logic          core_hold;

    modport master (
        input  start, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, error, core_hold
    );

    modport slave (
        output start, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, error, core_hold
    );
endinterface
`default_nettype wire

// File: rtl/instmem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instmem_loader
//  Description : Receives a boot image (4-byte big-endian length, L data
//                bytes, one checksum byte) over a valid/ready byte stream,
//                writes the data bytes to instruction memory and keeps the
//                core in reset until a complete, verified image is loaded.
//  Revision    : 1.0  initial release
// ============================================================================
module instmem_loader #(
    parameter int LENGTH = 10,
    parameter bit CHK_EN = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    instmem_loader_if.master  bus
);
    localparam int          AW        = $clog2(LENGTH);
    localparam logic [31:0] c_LEN_MAX = 32'(LENGTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [23:0]   r_hdr;      // first three header bytes, oldest in the MSBs
    logic [1:0]    r_hcnt;     // header bytes received
    logic [AW:0]   r_len;      // data length; only meaningful once <= LENGTH
    logic [AW:0]   r_dcnt;     // data bytes received, doubles as write address
    logic [7:0]    r_sum;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;

    logic          w_in_ready;
    logic          w_xfer;
    logic          w_start_ok;
    logic [31:0]   w_len_full;
    logic [AW:0]   w_dcnt_inc;
    logic [7:0]    w_sum_next;

    // Ready is a pure state decode so it never depends on in_valid.
    assign w_in_ready = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CHK);
    assign w_xfer     = bus.in_valid && w_in_ready;
    assign w_start_ok = bus.start &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_len_full = {r_hdr, bus.in_data};
    assign w_dcnt_inc = r_dcnt + 1'b1;
    assign w_sum_next = r_sum + bus.in_data;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    w_next = S_HDR;
                end
            end
            S_HDR: begin
                if (w_xfer && (r_hcnt == 2'd3)) begin
                    if (w_len_full > c_LEN_MAX) begin
                        w_next = S_ERR;
                    end else if (w_len_full == 32'd0) begin
                        w_next = S_CHK;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer && (w_dcnt_inc == r_len)) begin
                    w_next = S_CHK;
                end
            end
            S_CHK: begin
                if (w_xfer) begin
                    if ((w_sum_next == 8'd0) || !CHK_EN) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_ERR;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Header assembly, data counting, checksum and the registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr     <= '0;
            r_hcnt    <= '0;
            r_len     <= '0;
            r_dcnt    <= '0;
            r_sum     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_start_ok) begin
                r_hdr  <= '0;
                r_hcnt <= '0;
                r_len  <= '0;
                r_dcnt <= '0;
                r_sum  <= '0;
            end
            if (w_xfer && (r_state == S_HDR)) begin
                // The length is latched on every header byte; the value from
                // the fourth byte is the one that survives. It is only used
                // when it passed the LENGTH check, so the truncation is safe.
                r_hdr  <= w_len_full[23:0];
                r_hcnt <= r_hcnt + 2'd1;
                r_len  <= w_len_full[AW:0];
            end
            if (w_xfer && (r_state == S_DATA)) begin
                // r_dcnt < r_len <= LENGTH here, so the address stays in range.
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_dcnt[AW-1:0];
                r_wr_data <= bus.in_data;
                r_sum     <= w_sum_next;
                r_dcnt    <= w_dcnt_inc;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_in_ready;
    assign bus.done      = (r_state == S_DONE);
    assign bus.error     = (r_state == S_ERR);
    assign bus.core_hold = (r_state != S_DONE);
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_instmem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instmem_loader
//  Description : Directed, table-driven bench for instmem_loader (LENGTH=10).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instmem_loader;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instmem_loader_if #(.LENGTH(10)) bus ();

    instmem_loader #(.LENGTH(10), .CHK_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0]      hdr;
        int               ndata;
        logic [11:0][7:0] data;
        bit               send_chk;
        logic [7:0]       chk;
        bit               gaps;
        bit               hold_start;
        bit               exp_done;
        bit               exp_err;
        int               exp_writes;
    } vec_t;

    vec_t       vecs [7];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] wq_addr [$];
    logic [7:0] wq_data [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Write collector plus per-cycle invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            check("core_hold_vs_done", 32'(bus.core_hold), 32'(!bus.done));
            if (bus.wr_en === 1'b1) begin
                check("wr_addr_in_range", 32'(bus.wr_addr < 4'd10), 32'd1);
                wq_addr.push_back(bus.wr_addr);
                wq_data.push_back(bus.wr_data);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
        check({tag, "_wr_en"},     32'(bus.wr_en),     32'd0);
        check({tag, "_wr_addr"},   32'(bus.wr_addr),   32'd0);
        check({tag, "_wr_data"},   32'(bus.wr_data),   32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_done"},      32'(bus.done),      32'd0);
        check({tag, "_error"},     32'(bus.error),     32'd0);
        check({tag, "_core_hold"}, 32'(bus.core_hold), 32'd1);
    endtask

    // Start pulse with a byte offered at the same time; in_ready is 0 then,
    // so that byte must never be taken as a header byte.
    task automatic start_session(input bit hold);
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (hold) begin
            @(negedge clk);    // start still high while in HDR: ignored
        end
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL in_ready_timeout: actual=0 required=1");
        end
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int gap;
        wq_addr.delete();
        wq_data.delete();
        start_session(v.hold_start);
        for (int i = 0; i < 4; i++) begin
            send_byte(v.hdr[31-8*i -: 8], 0);
        end
        for (int i = 0; i < v.ndata; i++) begin
            gap = v.gaps ? int'($urandom_range(0, 3)) : 0;
            send_byte(v.data[i], gap);
        end
        if (v.send_chk) begin
            send_byte(v.chk, v.gaps ? 2 : 0);
        end
        bus.in_valid = 1'b0;
        check({nm, "_done"},      32'(bus.done),      32'(v.exp_done));
        check({nm, "_error"},     32'(bus.error),     32'(v.exp_err));
        check({nm, "_core_hold"}, 32'(bus.core_hold), 32'(!v.exp_done));
        check({nm, "_busy"},      32'(bus.busy),      32'd0);
        check({nm, "_in_ready"},  32'(bus.in_ready),  32'd0);
        @(negedge clk);
        check({nm, "_nwrites"}, 32'(wq_addr.size()), 32'(v.exp_writes));
        for (int k = 0; k < v.exp_writes && k < wq_addr.size(); k++) begin
            check({nm, "_waddr"}, 32'(wq_addr[k]), 32'(k));
            check({nm, "_wdata"}, 32'(wq_data[k]), 32'(v.data[k]));
        end
    endtask

    task automatic init_vecs();
        for (int i = 0; i < 7; i++) begin
            vecs[i].hdr = '0;        vecs[i].ndata = 0;       vecs[i].data = '0;
            vecs[i].send_chk = 1'b1; vecs[i].chk = 8'h00;     vecs[i].gaps = 1'b0;
            vecs[i].hold_start = 1'b0;
            vecs[i].exp_done = 1'b0; vecs[i].exp_err = 1'b0;  vecs[i].exp_writes = 0;
        end
        // 0x13+0x05+0x10+0x00 = 0x28, so 0xD8 brings the sum to zero.
        vecs[0].hdr = 32'h0000_0004; vecs[0].ndata = 4;
        vecs[0].data[0] = 8'h13; vecs[0].data[1] = 8'h05;
        vecs[0].data[2] = 8'h10; vecs[0].data[3] = 8'h00;
        vecs[0].chk = 8'hD8; vecs[0].exp_done = 1'b1; vecs[0].exp_writes = 4;
        // Same image, checksum off by one.
        vecs[1] = vecs[0];
        vecs[1].chk = 8'hD9; vecs[1].exp_done = 1'b0; vecs[1].exp_err = 1'b1;
        // L = 11 exceeds memory: error right after the header.
        vecs[2].hdr = 32'h0000_000B; vecs[2].send_chk = 1'b0; vecs[2].exp_err = 1'b1;
        // Empty image, good and bad checksum.
        vecs[3].chk = 8'h00; vecs[3].exp_done = 1'b1;
        vecs[4].chk = 8'h01; vecs[4].exp_err  = 1'b1;
        // Full memory with gaps; 1+2+..+10 = 0x37, closing byte 0xC9.
        vecs[5].hdr = 32'h0000_000A; vecs[5].ndata = 10;
        for (int i = 0; i < 10; i++) vecs[5].data[i] = 8'(i + 1);
        vecs[5].chk = 8'hC9; vecs[5].gaps = 1'b1; vecs[5].hold_start = 1'b1;
        vecs[5].exp_done = 1'b1; vecs[5].exp_writes = 10;
        // Oversize length carried in the top header byte.
        vecs[6].hdr = 32'h0100_0004; vecs[6].send_chk = 1'b0; vecs[6].exp_err = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        init_vecs();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("idle_after_reset");

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset after the second data byte; the third byte is on offer.
        wq_addr.delete();
        wq_data.delete();
        start_session(1'b0);
        for (int i = 0; i < 4; i++) send_byte(vecs[0].hdr[31-8*i -: 8], 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h10;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_nwrites", 32'(wq_addr.size()), 32'd2);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_hold_after_rst", 32'(bus.busy), 32'd0);
        run_vec(vecs[0], "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
